wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Write-side feeder for the pipeline's 15-entry register file (R0–R14), which has a single write port.
- Accepts register write-back requests from two producers: the ALU path and the memory-load path. Both may issue in the same cycle.
- Buffers requests in an in-order queue and drives exactly one register-file write per cycle.
- Tells the hazard unit which source registers still have writes in flight.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DATA_W, 32, result width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_wb_en  in  1  memory-path write request.
- mem_dest  in  4  memory-path destination register.
- mem_result  in  DATA_W  memory-path data.
- alu_wb_en  in  1  ALU-path write request.
- alu_dest  in  4  ALU-path destination register.
- alu_result  in  DATA_W  ALU-path data.
- src1  in  4  hazard-query register 1.
- src2  in  4  hazard-query register 2.
- WriteBackEn  out  1  register-file write enable.
- Dest_wb  out  4  register-file write index.
- Result_WB  out  DATA_W  register-file write data.
- src1_pending  out  1  src1 has a queued write.
- src2_pending  out  1  src2 has a queued write.
- stall  out  1  producers must not issue this cycle.
- overflow  out  1  sticky: a request was dropped.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - count=0, pointers=0, overflow=0.
  - All stored entries invalid.
  - Reset wins over any push or pop in the same cycle; an in-flight queue is discarded.
- Head outputs (combinational from storage):
  - WriteBackEn = (count != 0).
  - Dest_wb / Result_WB = head entry when count != 0, else 0.
  - The register file samples them on the falling edge. Each rising edge with count != 0 pops the head.
  - Latency: a request accepted at edge N is written at the falling edge after N when the queue was empty.
- Push rules, evaluated at the rising edge:
  - A request is a push only if its en=1 and dest != 4'd15. Writes to R15 are silently discarded and never counted.
  - Same-cycle ordering: the mem entry is enqueued before the ALU entry (mem is the older instruction). Two pushes to the same dest are both kept; the ALU value reaches the register file last.
  - Available space = DEPTH − count + pop.
  - Pushes are accepted in order (mem, then ALU) while space remains. Each rejected push sets overflow, which holds until rst.
- Count update: count_next = count + accepted_pushes − pop. Simultaneous push and pop are legal at any occupancy.
- stall = (count >= DEPTH−1), combinational from count. This guarantees two pushes fit even with no pop. Producers honour it; overflow flags protocol violations only.
- Pending flags:
  - srcX_pending = 1 iff srcX != 15 and some valid stored entry, including the head being written this cycle, has dest == srcX.
  - Requests arriving this cycle are not included.
- Pointers wrap modulo DEPTH. Full = count == DEPTH; empty = count == 0.

Decomposition:
- Shared package:
  - wbq_entry_t typedef: {dest[3:0], data[DATA_W-1:0]}.
  - PC_REG = 4'd15.
  - WBQ_DEPTH_DEFAULT = 4.
- One sub-module, wbq_fifo_2w1r:
  - Circular storage with 2 push ports and 1 pop port.
  - Owns the pointers, count and per-entry valid bits.
  - Exposes the entries so the top level can form the pending compare.
- Top level holds the R15 filter, space check, overflow flag, stall and pending logic.

Test Plan:
1. Reset, then an idle cycle → WriteBackEn=0, Dest_wb=0, Result_WB=0, count=0, stall=0, overflow=0.
2. Single ALU push (dest 3, data 0xDEADBEEF) into an empty queue → next cycle WriteBackEn=1, Dest_wb=3, Result_WB=0xDEADBEEF, src1_pending=1 with src1=3; cycle after: count=0, WriteBackEn=0.
3. Mem (dest 5, 0x11) and ALU (dest 5, 0x22) pushed in the same cycle → two consecutive writes to R5: 0x11, then 0x22. src1_pending=1 with src1=5 through both cycles, 0 after.
4. Push to dest 15 with data 0x1234 → count unchanged, no write, src1_pending=0 with src1=15.
5. Push 2 per cycle from empty with DEPTH=4 → stall=1 once count reaches 3. Forcing another double push while count=4 with a pop accepts mem, rejects ALU, and sets overflow=1; overflow stays 1 until rst.
6. Assert rst with count=3 → next cycle count=0, WriteBackEn=0, pending flags 0, overflow=0; any push issued in the reset cycle is discarded.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
package wb_write_queue_pkg;

  localparam logic [3:0] PC_REG            = 4'd15;
  localparam int         WBQ_DEPTH_DEFAULT = 4;
  localparam int         WBQ_DATA_W        = 32;

  typedef struct packed {
    logic [3:0]            dest;
    logic [WBQ_DATA_W-1:0] data;
  } wbq_entry_t;

  // R15 is the PC and is never written through this queue.
  function automatic logic is_push(input logic en, input logic [3:0] dest);
    return en && (dest != PC_REG);
  endfunction

endpackage

// File: rtl/wbq_fifo_2w1r.sv
// Circular buffer with two ordered push ports and one pop port.
// push1 is only ever asserted together with push0; din0 is the older entry.
module wbq_fifo_2w1r
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0,
  input  logic                   push1,
  input  wbq_entry_t             din0,
  input  wbq_entry_t             din1,
  input  logic                   pop,
  output wbq_entry_t             head,
  output wbq_entry_t             entries [DEPTH],
  output logic [DEPTH-1:0]       valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       n_push;
  wbq_entry_t       mem [DEPTH];

  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign n_push    = {1'b0, push0} + {1'b0, push1};
  assign head      = mem[rd_ptr];
  assign entries   = mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      // The pop clear comes first so a push landing on the slot being
      // vacated (full queue, simultaneous push and pop) leaves it valid.
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (push0) valid[wr_ptr]    <= 1'b1;
      if (push1) valid[wr_ptr_p1] <= 1'b1;
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      count  <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone say which
  // slots hold live data, so the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]    <= din0;
    if (push1) mem[wr_ptr_p1] <= din1;
  end

endmodule

// File: rtl/wb_write_queue.sv
// Merges ALU and memory write-backs into one in-order register-file write
// per cycle, and reports which source registers still have writes queued.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH_DEFAULT,
  parameter int DATA_W = WBQ_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_wb_en,
  input  logic [3:0]             mem_dest,
  input  logic [DATA_W-1:0]      mem_result,
  input  logic                   alu_wb_en,
  input  logic [3:0]             alu_dest,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [3:0]             src1,
  input  logic [3:0]             src2,
  output logic                   WriteBackEn,
  output logic [3:0]             Dest_wb,
  output logic [DATA_W-1:0]      Result_WB,
  output logic                   src1_pending,
  output logic                   src2_pending,
  output logic                   stall,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             mem_req, alu_req;
  logic             mem_acc, alu_acc;
  logic             pop;
  logic [CNT_W:0]   space;
  wbq_entry_t       mem_entry, alu_entry, din0, head;
  wbq_entry_t       entries [DEPTH];
  logic [DEPTH-1:0] valid;

  assign mem_req = is_push(mem_wb_en, mem_dest);
  assign alu_req = is_push(alu_wb_en, alu_dest);
  assign pop     = (count != '0);

  // Storage width is fixed by the shared entry type; results are resized to it.
  assign mem_entry = '{dest: mem_dest, data: WBQ_DATA_W'(mem_result)};
  assign alu_entry = '{dest: alu_dest, data: WBQ_DATA_W'(alu_result)};

  // The head pop frees its slot in the same edge, so it counts as space.
  assign space   = (CNT_W+1)'(DEPTH) - (CNT_W+1)'(count) + (CNT_W+1)'(pop);
  assign mem_acc = mem_req && (space != '0);
  assign alu_acc = alu_req && (space > {{CNT_W{1'b0}}, mem_acc});

  // Mem is the older instruction, so it always takes the first slot.
  assign din0 = mem_acc ? mem_entry : alu_entry;

  wbq_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push0   (mem_acc | alu_acc),
    .push1   (mem_acc & alu_acc),
    .din0    (din0),
    .din1    (alu_entry),
    .pop     (pop),
    .head    (head),
    .entries (entries),
    .valid   (valid),
    .count   (count)
  );

  assign WriteBackEn = pop;
  assign Dest_wb     = pop ? head.dest : '0;
  assign Result_WB   = pop ? DATA_W'(head.data) : '0;
  assign stall       = (count >= CNT_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst)                                          overflow <= 1'b0;
    else if ((mem_req && !mem_acc) || (alu_req && !alu_acc)) overflow <= 1'b1;
  end

  always_comb begin
    src1_pending = 1'b0;
    src2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i].dest == src1) src1_pending = 1'b1;
      if (valid[i] && entries[i].dest == src2) src2_pending = 1'b1;
    end
    if (src1 == PC_REG) src1_pending = 1'b0;
    if (src2 == PC_REG) src2_pending = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model plus a negedge
// monitor that scores every register-file write and status output.
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              mem_wb_en, alu_wb_en;
  logic [3:0]        mem_dest, alu_dest, src1, src2;
  logic [DATA_W-1:0] mem_result, alu_result;
  logic              WriteBackEn, src1_pending, src2_pending, stall, overflow;
  logic [3:0]        Dest_wb;
  logic [DATA_W-1:0] Result_WB;
  logic [2:0]        count;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .mem_result   (mem_result),
    .alu_wb_en    (alu_wb_en),
    .alu_dest     (alu_dest),
    .alu_result   (alu_result),
    .src1         (src1),
    .src2         (src2),
    .WriteBackEn  (WriteBackEn),
    .Dest_wb      (Dest_wb),
    .Result_WB    (Result_WB),
    .src1_pending (src1_pending),
    .src2_pending (src2_pending),
    .stall        (stall),
    .overflow     (overflow),
    .count        (count)
  );

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t model_q [$];  // reference queue contents, head first
  wr_t exp_q   [$];  // scoreboard of writes still to appear at the register file
  bit  model_ovf;
  bit  mon_on;
  int  total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pending(input logic [3:0] s);
    if (s == 4'd15) return 1'b0;
    foreach (model_q[i]) if (model_q[i].dest == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_push(input logic en, input logic [3:0] d, input logic [31:0] v);
    wr_t e;
    if (!en || d == 4'd15) return;
    if (model_q.size() < DEPTH) begin
      e.dest = d;
      e.data = v;
      model_q.push_back(e);
      exp_q.push_back(e);
    end else begin
      model_ovf = 1'b1;
    end
  endfunction

  // One clock cycle: drive inputs after the negedge, then advance the model at the posedge.
  task automatic step(input bit r,
                      input bit me, input logic [3:0] md, input logic [31:0] mr,
                      input bit ae, input logic [3:0] ad, input logic [31:0] ar,
                      input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clk);
    #2;
    rst = r;
    mem_wb_en = me; mem_dest = md; mem_result = mr;
    alu_wb_en = ae; alu_dest = ad; alu_result = ar;
    src1 = s1; src2 = s2;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      exp_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (model_q.size() != 0) void'(model_q.pop_front());
      model_push(me, md, mr);
      model_push(ae, ad, ar);
    end
  endtask

  task automatic idle(input logic [3:0] s1, input logic [3:0] s2);
    step(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, s1, s2);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mon_on) begin
      check("wb_en", WriteBackEn, model_q.size() != 0);
      if (WriteBackEn) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got dest %0d data %0h want no write at %0t",
                   Dest_wb, Result_WB, $time);
        end else begin
          e = exp_q.pop_front();
          check("wb_dest", Dest_wb, e.dest);
          check("wb_data", Result_WB, e.data);
        end
      end else begin
        check("idle_dest", Dest_wb, 0);
        check("idle_data", Result_WB, 0);
      end
      check("count", count, model_q.size());
      check("stall", stall, model_q.size() >= DEPTH - 1);
      check("overflow", overflow, model_ovf);
      check("src1_pending", src1_pending, model_pending(src1));
      check("src2_pending", src2_pending, model_pending(src2));
    end
  end

  initial begin
    bit me, ae;
    total = 0; bad = 0; mon_on = 1'b0; model_ovf = 1'b0;
    rst = 1'b1;
    mem_wb_en = 0; mem_dest = 0; mem_result = 0;
    alu_wb_en = 0; alu_dest = 0; alu_result = 0;
    src1 = 0; src2 = 0;

    step(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 4'd0, 4'd0);
    step(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 4'd0, 4'd0);
    mon_on = 1'b1;

    // Reset state on an idle cycle.
    idle(4'd0, 4'd1);

    // Single ALU push, then it drains.
    step(0, 0, 4'd0, 32'd0, 1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd0);
    idle(4'd3, 4'd0);
    idle(4'd3, 4'd0);

    // Same-cycle pair to the same register: mem value first, ALU value last.
    step(0, 1, 4'd5, 32'h11, 1, 4'd5, 32'h22, 4'd5, 4'd2);
    idle(4'd5, 4'd2);
    idle(4'd5, 4'd2);
    idle(4'd5, 4'd2);

    // Writes to R15 are dropped silently, from either path.
    step(0, 0, 4'd0, 32'd0, 1, 4'd15, 32'h1234, 4'd15, 4'd15);
    step(0, 1, 4'd15, 32'h99, 0, 4'd0, 32'd0, 4'd15, 4'd0);
    idle(4'd15, 4'd0);

    // Double pushes ignoring stall: fill, then overflow on the ALU entry.
    for (int i = 0; i < 5; i++)
      step(0, 1, 4'(i), 32'h100 + i, 1, 4'(i + 8), 32'h200 + i, 4'(i), 4'(i + 8));
    for (int i = 0; i < 5; i++) idle(4'd2, 4'd11);

    // Reset with entries in flight discards them and any same-cycle push.
    step(0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2, 4'd1, 4'd2);
    step(0, 1, 4'd3, 32'hA3, 1, 4'd4, 32'hA4, 4'd1, 4'd2);
    step(1, 1, 4'd6, 32'hA5, 1, 4'd7, 32'hA6, 4'd1, 4'd6);
    idle(4'd1, 4'd6);
    idle(4'd7, 4'd3);

    // Randomized traffic; producers mostly honour stall.
    for (int i = 0; i < 600; i++) begin
      me = ($urandom_range(0, 2) != 0);
      ae = ($urandom_range(0, 2) != 0);
      if (model_q.size() >= DEPTH - 1 && $urandom_range(0, 9) != 0) begin
        me = 0;
        ae = 0;
      end
      step(($urandom_range(0, 79) == 0),
           me, 4'($urandom_range(0, 15)), $urandom,
           ae, 4'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 8; i++) idle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    @(negedge clk);
    #1;
    check("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
